// File: rtl/mips_alu_pkg.sv
// Shared opcode/funct codes, internal operation and state enums, and the
// decode helper used by the ALU execute stage.
package mips_alu_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADD   = 6'h20;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SUB   = 6'h22;
    localparam logic [5:0] OPC_SLT   = 6'h2A;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [4:0] {
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
        OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_LUI,
        OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
        OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
        OP_ILLEGAL
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, MULDIV, FIXUP} state_e;

    typedef enum logic {MD_MUL, MD_DIV} md_op_e;

    function automatic alu_op_e decode_op(input logic arith, input logic [5:0] opc,
                                          input logic [5:0] fn);
        alu_op_e op;
        op = OP_ILLEGAL;
        if (arith && opc == OPC_RTYPE) begin
            case (fn)
                FN_ADD:   op = OP_ADD;
                FN_ADDU:  op = OP_ADDU;
                FN_SUB:   op = OP_SUB;
                FN_SUBU:  op = OP_SUBU;
                FN_AND:   op = OP_AND;
                FN_OR:    op = OP_OR;
                FN_XOR:   op = OP_XOR;
                FN_NOR:   op = OP_NOR;
                FN_SLT:   op = OP_SLT;
                FN_SLTU:  op = OP_SLTU;
                FN_SLL:   op = OP_SLL;
                FN_SRL:   op = OP_SRL;
                FN_SRA:   op = OP_SRA;
                FN_SLLV:  op = OP_SLLV;
                FN_SRLV:  op = OP_SRLV;
                FN_SRAV:  op = OP_SRAV;
                FN_MULT:  op = OP_MULT;
                FN_MULTU: op = OP_MULTU;
                FN_DIV:   op = OP_DIV;
                FN_DIVU:  op = OP_DIVU;
                FN_MFHI:  op = OP_MFHI;
                FN_MFLO:  op = OP_MFLO;
                FN_MTHI:  op = OP_MTHI;
                FN_MTLO:  op = OP_MTLO;
                default:  op = OP_ILLEGAL;
            endcase
        end else begin
            case (opc)
                OPC_ADD, OPC_ADDI:  op = OP_ADD;
                OPC_ADDIU:          op = OP_ADDU;
                OPC_SUB:            op = OP_SUB;
                OPC_SLT, OPC_SLTI:  op = OP_SLT;
                OPC_SLTIU:          op = OP_SLTU;
                OPC_ANDI:           op = OP_AND;
                OPC_ORI:            op = OP_OR;
                OPC_XORI:           op = OP_XOR;
                OPC_LUI:            op = OP_LUI;
                default:            op = OP_ILLEGAL;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative 32-step shift-add multiplier / restoring divider working on
// operand magnitudes; sign fix-up is applied combinationally on hi/lo.
module muldiv_iter
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg, opnd_reg, a_orig_reg;
    logic             neg_q_reg, neg_r_reg, is_div_reg, div_zero_reg;
    logic             active_reg, done_reg;
    logic [4:0]       cnt_reg;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg = is_signed && a[WIDTH-1];
    assign b_neg = is_signed && b[WIDTH-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    // acc_lo holds the multiplier (mul) or the dividend shifting into quotient (div)
    logic [WIDTH:0]   mul_sum, div_part, div_trial;
    logic             div_ok;

    assign mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
    assign div_part  = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_ok    = div_part >= {1'b0, opnd_reg};
    assign div_trial = div_part - {1'b0, opnd_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hi_reg   <= '0;
            acc_lo_reg   <= '0;
            opnd_reg     <= '0;
            a_orig_reg   <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            is_div_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            active_reg   <= 1'b0;
            done_reg     <= 1'b0;
            cnt_reg      <= '0;
        end else if (start) begin
            acc_hi_reg   <= '0;
            acc_lo_reg   <= a_mag;
            opnd_reg     <= b_mag;
            a_orig_reg   <= a;
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            is_div_reg   <= (op == MD_DIV);
            div_zero_reg <= (b == '0);
            active_reg   <= 1'b1;
            done_reg     <= 1'b0;
            cnt_reg      <= '0;
        end else if (active_reg) begin
            if (is_div_reg) begin
                acc_hi_reg <= div_ok ? div_trial[WIDTH-1:0] : div_part[WIDTH-1:0];
                acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], div_ok};
            end else begin
                acc_hi_reg <= mul_sum[WIDTH:1];
                acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
            end
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == 5'd31) begin
                active_reg <= 1'b0;
                done_reg   <= 1'b1;
            end
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    assign prod_fix = neg_q_reg ? (~{acc_hi_reg, acc_lo_reg} + 1'b1) : {acc_hi_reg, acc_lo_reg};

    always_comb begin
        hi = prod_fix[2*WIDTH-1:WIDTH];
        lo = prod_fix[WIDTH-1:0];
        if (is_div_reg) begin
            // Divide-by-zero bypasses sign fix-up: all-ones quotient, dividend as remainder
            if (div_zero_reg) begin
                lo = '1;
                hi = a_orig_reg;
            end else begin
                lo = neg_q_reg ? (~acc_lo_reg + 1'b1) : acc_lo_reg;
                hi = neg_r_reg ? (~acc_hi_reg + 1'b1) : acc_hi_reg;
            end
        end
    end

    assign done = done_reg;

endmodule

// File: rtl/alu_exec.sv
// MIPS-style execute stage: single-cycle ALU datapath with valid/ready
// handshake, plus HI/LO registers fed by the iterative mul/div unit.
module alu_exec
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       alu_opcode,
    input  logic             arithmetic_op,
    input  logic [5:0]       funct,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             busy
);

    state_e           state_reg, state_next;
    logic [4:0]       iter_cnt_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg, result_reg;
    logic             out_valid_reg, overflow_reg, illegal_reg;

    alu_op_e          op;
    logic             accept, op_is_md, md_start, md_done;
    logic [WIDTH-1:0] md_hi, md_lo;

    assign op       = decode_op(arithmetic_op, alu_opcode, funct);
    assign op_is_md = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign in_ready = (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign md_start = accept && op_is_md;

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .is_signed ((op == OP_MULT) || (op == OP_DIV)),
        .op        (((op == OP_DIV) || (op == OP_DIVU)) ? MD_DIV : MD_MUL),
        .a         (a),
        .b         (b),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    logic [WIDTH-1:0] sum, diff, alu_result;
    logic             alu_ovf, alu_ill;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        alu_ill    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_result = sum;
                alu_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: alu_result = sum;
            OP_SUB: begin
                alu_result = diff;
                alu_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU:  alu_result = diff;
            OP_AND:   alu_result = a & b;
            OP_OR:    alu_result = a | b;
            OP_XOR:   alu_result = a ^ b;
            OP_NOR:   alu_result = ~(a | b);
            OP_SLT:   alu_result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:  alu_result = {{(WIDTH-1){1'b0}}, a < b};
            OP_LUI:   alu_result = b << 16;
            OP_SLL:   alu_result = b << shamt;
            OP_SRL:   alu_result = b >> shamt;
            OP_SRA:   alu_result = $signed(b) >>> shamt;
            OP_SLLV:  alu_result = b << a[4:0];
            OP_SRLV:  alu_result = b >> a[4:0];
            OP_SRAV:  alu_result = $signed(b) >>> a[4:0];
            OP_MFHI:  alu_result = hi_reg;
            OP_MFLO:  alu_result = lo_reg;
            OP_ILLEGAL: alu_ill  = 1'b1;
            default:  alu_result = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (md_start) state_next = MULDIV;
            MULDIV:  if (iter_cnt_reg == 5'd31) state_next = FIXUP;
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            iter_cnt_reg  <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            iter_cnt_reg <= (state_reg == MULDIV) ? iter_cnt_reg + 1'b1 : '0;
            if (out_valid_reg && out_ready)
                out_valid_reg <= 1'b0;
            // Result fields only change on a new accept or mul/div completion, so a held result is stable
            if (accept && !op_is_md) begin
                result_reg    <= alu_result;
                overflow_reg  <= alu_ovf;
                illegal_reg   <= alu_ill;
                out_valid_reg <= 1'b1;
                if (op == OP_MTHI) hi_reg <= a;
                if (op == OP_MTLO) lo_reg <= a;
            end
            if (state_reg == FIXUP && md_done) begin
                hi_reg        <= md_hi;
                lo_reg        <= md_lo;
                result_reg    <= '0;
                overflow_reg  <= 1'b0;
                illegal_reg   <= 1'b0;
                out_valid_reg <= 1'b1;
            end
        end
    end

    assign result    = result_reg;
    assign zero      = (result_reg == '0);
    assign overflow  = overflow_reg;
    assign illegal   = illegal_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: table of single-cycle vectors plus hand
// sequences for mul/div latency, HI/LO, backpressure and mid-op reset.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [5:0]  alu_opcode, funct;
    logic        arithmetic_op;
    logic [4:0]  shamt;
    logic [31:0] a, b, result;
    logic        out_valid, out_ready, zero, overflow, illegal, busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_exec #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_opcode(alu_opcode), .arithmetic_op(arithmetic_op), .funct(funct),
        .shamt(shamt), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow), .illegal(illegal), .busy(busy)
    );

    typedef struct packed {
        logic        arith;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] res;
        logic        ovf;
        logic        ill;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic arith, input logic [5:0] opc, input logic [5:0] fn,
                                input logic [4:0] sh, input logic [31:0] av, input logic [31:0] bv,
                                input logic [31:0] res, input logic ovf, input logic ill);
        vec_t v;
        v.arith = arith; v.opc = opc; v.fn = fn; v.sh = sh;
        v.av = av; v.bv = bv; v.res = res; v.ovf = ovf; v.ill = ill;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present an operation at a negedge, wait (bounded) for in_ready, return #1 after the accept edge
    task automatic drive(input logic arith, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] av, input logic [31:0] bv);
        int t;
        @(negedge clk);
        arithmetic_op = arith; alu_opcode = opc; funct = fn; shamt = sh; a = av; b = bv;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("in_ready_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic apply(input string name, input vec_t v);
        drive(v.arith, v.opc, v.fn, v.sh, v.av, v.bv);
        $display("%s: arith=%0d opc=%h fn=%h a=%h b=%h -> result=%h ovf=%0d ill=%0d",
                 name, v.arith, v.opc, v.fn, v.av, v.bv, result, overflow, illegal);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_result"}, result, v.res);
        check({name, "_ovf"}, 32'(overflow), 32'(v.ovf));
        check({name, "_ill"}, 32'(illegal), 32'(v.ill));
        check({name, "_zero"}, 32'(zero), 32'(v.res == 32'd0));
    endtask

    task automatic run_md(input string name, input logic [5:0] fn,
                          input logic [31:0] av, input logic [31:0] bv);
        int edges;
        drive(1'b1, 6'h00, fn, 5'd0, av, bv);
        check({name, "_busy"}, 32'(busy), 32'd1);
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        $display("%s: a=%h b=%h done after %0d edges", name, av, bv, edges);
        check({name, "_latency"}, 32'(edges), 32'd33);
        check({name, "_result"}, result, 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic read_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        apply({name, "_mfhi"}, mk(1'b1, 6'h00, 6'h10, 5'd0, 32'd0, 32'd0, exp_hi, 1'b0, 1'b0));
        apply({name, "_mflo"}, mk(1'b1, 6'h00, 6'h12, 5'd0, 32'd0, 32'd0, exp_lo, 1'b0, 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int stall_bad;
        int edges;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_opcode = '0; arithmetic_op = 1'b0; funct = '0; shamt = '0; a = '0; b = '0;

        // Single-cycle vectors: arith, opcode, funct, shamt, a, b, result, overflow, illegal
        vt.push_back(mk(1, 6'h00, 6'h20, 0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1, 0));
        vt.push_back(mk(1, 6'h00, 6'h21, 0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 0));
        vt.push_back(mk(1, 6'h00, 6'h22, 0, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1, 0));
        vt.push_back(mk(1, 6'h00, 6'h23, 0, 32'h5,        32'h7,        32'hFFFFFFFE, 0, 0));
        vt.push_back(mk(1, 6'h00, 6'h24, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0));
        vt.push_back(mk(1, 6'h00, 6'h25, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0));
        vt.push_back(mk(1, 6'h00, 6'h26, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0));
        vt.push_back(mk(1, 6'h00, 6'h27, 0, 32'h0,        32'h0,        32'hFFFFFFFF, 0, 0));
        vt.push_back(mk(0, 6'h0B, 6'h00, 0, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 0));
        vt.push_back(mk(1, 6'h00, 6'h2A, 0, 32'hFFFFFFFF, 32'h1,        32'h1,        0, 0));
        vt.push_back(mk(1, 6'h00, 6'h2B, 0, 32'h1,        32'hFFFFFFFF, 32'h1,        0, 0));
        vt.push_back(mk(1, 6'h00, 6'h00, 4, 32'h0,        32'h0000000F, 32'h000000F0, 0, 0));
        vt.push_back(mk(1, 6'h00, 6'h02, 4, 32'h0,        32'h80000000, 32'h08000000, 0, 0));
        vt.push_back(mk(1, 6'h00, 6'h03, 4, 32'h0,        32'h80000000, 32'hF8000000, 0, 0));
        vt.push_back(mk(1, 6'h00, 6'h04, 0, 32'h21,       32'h1,        32'h2,        0, 0));
        vt.push_back(mk(1, 6'h00, 6'h06, 0, 32'h1F,       32'h80000000, 32'h1,        0, 0));
        vt.push_back(mk(1, 6'h00, 6'h07, 0, 32'h1F,       32'h80000000, 32'hFFFFFFFF, 0, 0));
        vt.push_back(mk(0, 6'h0F, 6'h00, 0, 32'h0,        32'h1234,     32'h12340000, 0, 0));
        vt.push_back(mk(0, 6'h08, 6'h00, 0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1, 0));
        vt.push_back(mk(0, 6'h09, 6'h00, 0, 32'h1,        32'h2,        32'h3,        0, 0));
        vt.push_back(mk(0, 6'h0A, 6'h00, 0, 32'hFFFFFFFF, 32'h0,        32'h1,        0, 0));
        vt.push_back(mk(0, 6'h0C, 6'h00, 0, 32'hFF,       32'h0F,       32'h0F,       0, 0));
        vt.push_back(mk(0, 6'h0D, 6'h00, 0, 32'hF0,       32'h0F,       32'hFF,       0, 0));
        vt.push_back(mk(0, 6'h0E, 6'h00, 0, 32'hFF,       32'h0F,       32'hF0,       0, 0));
        vt.push_back(mk(1, 6'h20, 6'h3F, 0, 32'h1,        32'h1,        32'h2,        0, 0));
        vt.push_back(mk(1, 6'h00, 6'h3F, 0, 32'h1,        32'h1,        32'h0,        0, 1));
        vt.push_back(mk(0, 6'h00, 6'h20, 0, 32'h1,        32'h1,        32'h0,        0, 1));

        // Reset state
        #23;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        foreach (vt[i]) apply($sformatf("vec%0d", i), vt[i]);

        // mult -2*3 with mflo presented immediately: must stall until completion
        drive(1'b1, 6'h00, 6'h18, 5'd0, 32'hFFFFFFFE, 32'h3);
        arithmetic_op = 1'b1; alu_opcode = 6'h00; funct = 6'h12; a = '0; b = '0;
        in_valid = 1'b1;
        stall_bad = 0;
        edges = 0;
        while (!out_valid && edges < 100) begin
            if (busy && in_ready) stall_bad++;
            @(posedge clk);
            #1;
            edges++;
        end
        $display("mult: a=fffffffe b=3 done after %0d edges", edges);
        check("mult_latency", 32'(edges), 32'd33);
        check("mult_stall", 32'(stall_bad), 32'd0);
        check("mult_result", result, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("mflo after mult -> result=%h", result);
        check("mult_mflo", result, 32'hFFFFFFFA);
        apply("mult_mfhi", mk(1, 6'h00, 6'h10, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0));

        run_md("multu", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
        read_hilo("multu", 32'hFFFFFFFE, 32'h00000001);
        run_md("div", 6'h1A, 32'hFFFFFFF9, 32'h2);
        read_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("divu0", 6'h1B, 32'h5, 32'h0);
        read_hilo("divu0", 32'h5, 32'hFFFFFFFF);
        run_md("div_minovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF);
        read_hilo("div_minovf", 32'h0, 32'h80000000);
        run_md("divu", 6'h1B, 32'd100, 32'd7);
        read_hilo("divu", 32'd2, 32'd14);

        // Backpressure: result held for 5 cycles, then back-to-back accept on release
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive(1'b1, 6'h00, 6'h20, 5'd0, 32'd1, 32'd2);
        arithmetic_op = 1'b1; alu_opcode = 6'h00; funct = 6'h20; a = 32'd5; b = 32'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            $display("hold cycle %0d: result=%h out_valid=%0d in_ready=%0d", i, result, out_valid, in_ready);
            check("hold_result", result, 32'd3);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("release accept: result=%h", result);
        check("b2b_result", result, 32'd10);
        check("b2b_valid", 32'(out_valid), 32'd1);

        // Reset during divu: no HI/LO update, straight back to idle
        apply("mthi", mk(1, 6'h00, 6'h11, 0, 32'hAAAA5555, 32'h0, 32'h0, 0, 0));
        apply("mtlo", mk(1, 6'h00, 6'h13, 0, 32'h5555AAAA, 32'h0, 32'h0, 0, 0));
        read_hilo("mtx", 32'hAAAA5555, 32'h5555AAAA);
        drive(1'b1, 6'h00, 6'h1B, 5'd0, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) @(posedge clk);
        #2;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        $display("mid-divu reset: busy=%0d out_valid=%0d in_ready=%0d", busy, out_valid, in_ready);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_no_done", 32'(out_valid), 32'd0);
        read_hilo("arst", 32'h0, 32'h0);
        apply("illegal3f", mk(1, 6'h00, 6'h3F, 0, 32'h1234, 32'h5678, 32'h0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
